spi_flash_line_fetcher: RTL
===========================

Name: spi_flash_line_fetcher

Overview:
- Parametrised successor to the fixed-length VGA SPI ROM test reader.
- Accepts a start request with a 24-bit flash address and reads DATA_BYTES bytes from SPI flash, using either single-SPI (03h) or Quad Output Fast Read (6Bh).
- Stores the bytes in an internal byte-addressed line buffer. The video pipeline reads this buffer through a registered read port.
- Sits between the VGA timing/scheduling logic, which issues one start per line, and the pixel generator.

Parameters:
- DATA_BYTES, 17: bytes fetched per transaction and line-buffer depth (1..255).
- QSPI_DUMMY, 8: dummy SCLK cycles after ADDR in quad mode.
- BUF_AW, $clog2(DATA_BYTES): width of the read-port address.

Ports:
- clk  in  1  system clock; spi_sclk is derived from it.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a fetch; sampled on rising clk.
- quad  in  1  mode for this fetch: 0 = single 03h, 1 = quad 6Bh; latched with start.
- addr  in  24  flash byte address; latched with start.
- abort  in  1  synchronous cancel of an in-flight fetch.
- busy  out  1  high while a fetch is in progress.
- done  out  1  one-cycle pulse when the buffer holds a complete fetch.
- rd_addr  in  BUF_AW  line-buffer byte index.
- rd_data  out  8  byte at rd_addr; registered, 1-cycle latency.
- spi_cs  out  1  chip select, active HIGH; the parent inverts it.
- spi_sclk  out  1  equal to ~clk, continuous.
- spi_in  in  4  io[3:0] input side; io[1] is MISO in single mode.
- spi_out0  out  1  io0 output (MOSI).
- spi_dir0  out  1  io0 direction: 0 = output, 1 = input.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE; spi_cs=0, spi_out0=0, spi_dir0=0, busy=0, done=0, rd_data=0.
  - Buffer contents are not reset.
  - Reset mid-fetch drops CS immediately.
- States: IDLE -> CMD(8) -> ADDR(24) -> DUMMY(QSPI_DUMMY, quad only) -> DATA -> IDLE. A cycle counter runs inside each state.
- DATA length: 8*DATA_BYTES cycles (single) or 2*DATA_BYTES cycles (quad).
- Start acceptance:
  - start is honoured only in IDLE, including the cycle in which done is high.
  - addr and quad are latched on that edge.
  - The next cycle is CMD cycle 0, with spi_cs=1 and busy=1.
- spi_cs is high for exactly T = 32 + (quad ? QSPI_DUMMY : 0) + DATA cycles.
- spi_out0:
  - CMD cycle k drives cmd[7-k]; ADDR cycle k drives addr[23-k]. Everything is MSB first.
  - spi_out0=0 in all other cycles.
  - All outputs change on rising clk, so MOSI is stable at the rising edge of spi_sclk.
- spi_dir0 = 1 from the first cycle after ADDR until CS falls; 0 otherwise.
- Input capture:
  - spi_in is captured on falling clk (the rising edge of spi_sclk) into a capture register.
  - The capture register is consumed on the following rising clk.
- Byte assembly:
  - Single mode: MISO bits are packed MSB first, 8 bits per byte.
  - Quad mode: the first nibble is byte[7:4], the second is byte[3:0]; nibble = spi_in[3:0].
  - Byte n is written to buffer[n] when complete, so buffer index 0 receives the first byte.
- Completion:
  - The last byte is written on the rising edge that ends the final DATA cycle.
  - In the next cycle: spi_cs=0, busy=0, done=1 for one cycle, and all DATA_BYTES entries are valid.
- Read port:
  - rd_data <= buffer[rd_addr] on each rising clk.
  - rd_addr >= DATA_BYTES returns 8'h00.
  - Reading during a fetch returns new bytes for indices already written and stale bytes for the rest.
- Abort:
  - In any non-IDLE state, abort makes the next cycle IDLE with spi_cs=0, busy=0, and no done pulse.
  - Bytes already written stay in the buffer.
  - In IDLE, abort blocks a simultaneous start.
- A start received while busy is ignored and is not queued.
- Counters are sized for 8*255 + 32 + QSPI_DUMMY and never wrap within a legal transaction.

Test Plan:
- Single fetch: quad=0, addr=0x000120, DATA_BYTES=17, flash model holding byte i = i^0x5A. Required:
  - MOSI carries 0x03 then 0x000120.
  - spi_cs high for exactly 168 cycles; spi_dir0 rises at cycle 32.
  - done pulses 1 cycle after CS falls.
  - rd_addr 0..16 returns 0x5A,0x5B,...
- Quad fetch: quad=1, addr=0x001040, flash nibbles 0x1..0xF repeating. Required:
  - MOSI carries 0x6B + addr; 8 dummy cycles.
  - CS high for 32+8+34=74 cycles.
  - buffer[0]=0x12, buffer[1]=0x34.
- Abort at DATA cycle 20 (single mode). Required:
  - spi_cs=0 the next cycle and no done pulse.
  - buffer[0..1] updated, buffer[2..] unchanged.
  - A new start is accepted one cycle later.
- Assert reset_n=0 mid-ADDR. Required: spi_cs, busy and spi_out0 drop to 0 without waiting for a clk edge; after release, the block idles until start.
- start pulsed at cycles 5 and 50 of a fetch. Required: ignored, with exactly one done pulse. start held high in the done cycle begins a back-to-back fetch with CS rising the next cycle.
- rd_addr=17 and rd_addr=31 with DATA_BYTES=17. Required: rd_data=0x00 one cycle later.

Source files
------------

// File: rtl/spi_flash_line_fetcher.sv
// spi_flash_line_fetcher
// Reads DATA_BYTES bytes from SPI flash (single 03h or quad-output 6Bh) into a
// byte-addressed line buffer that the pixel pipeline reads through a
// registered port. One fetch per start request; abort cancels a fetch.
module spi_flash_line_fetcher #(
   parameter int DATA_BYTES = 17,
   parameter int QSPI_DUMMY = 8,
   parameter int BUF_AW     = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              quad,
   input  logic [23:0]       addr,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   input  logic [BUF_AW-1:0] rd_addr,
   output logic [7:0]        rd_data,
   output logic              spi_cs,
   output logic              spi_sclk,
   input  logic [3:0]        spi_in,
   output logic              spi_out0,
   output logic              spi_dir0
);

   // Sized so the longest legal phase (8*255 data cycles) never wraps.
   localparam int CNT_W = $clog2(8 * 255 + 32 + QSPI_DUMMY + 1);

   localparam logic [CNT_W-1:0] CMD_LAST    = CNT_W'(7);
   localparam logic [CNT_W-1:0] ADDR_LAST   = CNT_W'(23);
   localparam logic [CNT_W-1:0] DUMMY_LAST  = CNT_W'((QSPI_DUMMY > 0) ? QSPI_DUMMY - 1 : 0);
   localparam logic [CNT_W-1:0] SINGLE_LAST = CNT_W'(8 * DATA_BYTES - 1);
   localparam logic [CNT_W-1:0] QUAD_LAST   = CNT_W'(2 * DATA_BYTES - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DUMMY,
      ST_DATA
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [23:0]        addr_q, addr_d;
   logic               quad_q, quad_d;
   logic [6:0]         shift_q, shift_d;
   logic [3:0]         cap_q;
   logic               active_q, active_d;
   logic               done_q, done_d;
   logic               out0_q, out0_d;
   logic               dir0_q, dir0_d;
   logic [7:0]         rd_data_q;
   logic [7:0]         cmd_d;

   logic               wr_en;
   logic [BUF_AW-1:0]  wr_idx;
   logic [7:0]         wr_data;
   logic               rd_in_range;

   logic [7:0]         mem [DATA_BYTES];

   // Flash clock is the inverted system clock, so flash samples MOSI mid-cycle.
   assign spi_sclk = ~clk;

   // Input sample on the rising spi_sclk edge; consumed on the next rising clk.
   always_ff @(negedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cap_q <= 4'h0;
      end else begin
         cap_q <= spi_in;
      end
   end

   // Next-state, byte assembly and registered-output decode.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + 1'b1;
      addr_d   = addr_q;
      quad_d   = quad_q;
      shift_d  = shift_q;
      done_d   = 1'b0;
      wr_en    = 1'b0;
      wr_idx   = '0;
      wr_data  = 8'h00;
      active_d = 1'b0;
      dir0_d   = 1'b0;
      out0_d   = 1'b0;
      cmd_d    = 8'h00;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (start && !abort) begin
               state_d = ST_CMD;
               addr_d  = addr;
               quad_d  = quad;
            end
         end
         ST_CMD: begin
            if (cnt_q == CMD_LAST) begin
               state_d = ST_ADDR;
               cnt_d   = '0;
            end
         end
         ST_ADDR: begin
            if (cnt_q == ADDR_LAST) begin
               cnt_d   = '0;
               state_d = (quad_q && (QSPI_DUMMY > 0)) ? ST_DUMMY : ST_DATA;
            end
         end
         ST_DUMMY: begin
            if (cnt_q == DUMMY_LAST) begin
               state_d = ST_DATA;
               cnt_d   = '0;
            end
         end
         ST_DATA: begin
            // Shift in one bit (single) or one nibble (quad) per cycle.
            if (quad_q) begin
               shift_d = {shift_q[2:0], cap_q};
               wr_data = {shift_q[3:0], cap_q};
               wr_en   = cnt_q[0];
               wr_idx  = BUF_AW'(cnt_q >> 1);
            end else begin
               shift_d = {shift_q[5:0], cap_q[1]};
               wr_data = {shift_q[6:0], cap_q[1]};
               wr_en   = (cnt_q[2:0] == 3'd7);
               wr_idx  = BUF_AW'(cnt_q >> 3);
            end
            if (cnt_q == (quad_q ? QUAD_LAST : SINGLE_LAST)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Abort overrides any in-flight progression, including the final cycle.
      if ((state_q != ST_IDLE) && abort) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         done_d  = 1'b0;
      end

      // Outputs are decoded from the next state so they leave a flop.
      cmd_d    = quad_d ? 8'h6B : 8'h03;
      active_d = (state_d != ST_IDLE);
      dir0_d   = (state_d == ST_DUMMY) || (state_d == ST_DATA);
      if (state_d == ST_CMD) begin
         out0_d = cmd_d[~cnt_d[2:0]];
      end else if (state_d == ST_ADDR) begin
         out0_d = addr_d[5'd23 - cnt_d[4:0]];
      end
   end

   // Control state and output registers; reset drops CS at once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         addr_q   <= 24'h000000;
         quad_q   <= 1'b0;
         shift_q  <= 7'h00;
         active_q <= 1'b0;
         done_q   <= 1'b0;
         out0_q   <= 1'b0;
         dir0_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         quad_q   <= quad_d;
         shift_q  <= shift_d;
         active_q <= active_d;
         done_q   <= done_d;
         out0_q   <= out0_d;
         dir0_q   <= dir0_d;
      end
   end

   // Line buffer write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign rd_in_range = (32'(rd_addr) < 32'(DATA_BYTES));

   // Registered read port; indices past the line read as zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_data_q <= 8'h00;
      end else begin
         rd_data_q <= rd_in_range ? mem[rd_addr] : 8'h00;
      end
   end

   assign rd_data  = rd_data_q;
   assign spi_cs   = active_q;
   assign busy     = active_q;
   assign done     = done_q;
   assign spi_out0 = out0_q;
   assign spi_dir0 = dir0_q;

endmodule
